// File: rtl/conv_accel_hub_if.sv
// Host and lane signal bundle for conv_accel_hub; the hub connects through the slave modport,
// the host/lane side through the master modport.
interface conv_accel_hub_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
  logic [DATA_W-1:0]        dataInput;
  logic                     wr;
  logic                     newline;
  logic                     cStart;
  logic                     FULL;
  logic                     EMPTY;
  logic                     cReady;
  logic                     ovf;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_newline;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH*DATA_W-1:0] ch_sum;
  logic [NUM_CH-1:0]        ch_sum_valid;
  logic [NUM_CH-1:0]        ch_sum_ack;
  logic [DATA_W-1:0]        finalsum;
  logic [CH_W-1:0]          finalsum_ch;
  logic                     sum_valid;
  logic                     sum_rd;

  modport slave (
    input  dataInput, wr, newline, cStart, ch_ready, ch_sum, ch_sum_valid, sum_rd,
    output FULL, EMPTY, cReady, ovf, ch_data, ch_newline, ch_valid, ch_sum_ack,
           finalsum, finalsum_ch, sum_valid
  );

  modport master (
    output dataInput, wr, newline, cStart, ch_ready, ch_sum, ch_sum_valid, sum_rd,
    input  FULL, EMPTY, cReady, ovf, ch_data, ch_newline, ch_valid, ch_sum_ack,
           finalsum, finalsum_ch, sum_valid
  );
endinterface

// File: rtl/conv_accel_hub.sv
// Buffers tagged host words, deals whole lines round-robin to NUM_CH lanes and collects per-line sums
// into one result register (ack is combinational, result 1 cycle later). CONV_HUB_OVF_EN adds sticky ovf.
module conv_accel_hub #(
  parameter int DATA_W          = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int NUM_CH          = 2,
  parameter int LINES_PER_FRAME = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  conv_accel_hub_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(LINES_PER_FRAME + 1);

  localparam logic [AW:0]      DEPTH_C     = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LPF_C       = CNT_W'(LINES_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_LINE_C = CNT_W'(LINES_PER_FRAME - 1);
  localparam logic [CH_W-1:0]  CUR_MAX_C   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  logic [DATA_W:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]         count_q, count_d;
  state_t              state_q, state_d;
  logic [CH_W-1:0]     cur_q, cur_d;
  logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]    sum_cnt_q, sum_cnt_d;
  logic [DATA_W-1:0]   finalsum_q, finalsum_d;
  logic [CH_W-1:0]     finalsum_ch_q, finalsum_ch_d;
  logic                sum_valid_q, sum_valid_d;
  logic                cready_q, cready_d;

  logic                full, empty, push, xfer;
  logic [DATA_W-1:0]   head_dat;
  logic                head_nl;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_valid, ch_newline, ack;
  logic                ld;
  logic [CH_W-1:0]     sel;
  logic [DATA_W-1:0]   ld_sum;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push     = bus.wr && !full;
  assign head_dat = mem_q[rptr_q][DATA_W-1:0];
  assign head_nl  = mem_q[rptr_q][DATA_W];

  // Only the current lane sees the FIFO head; the others stay idle.
  always_comb begin
    ch_valid   = '0;
    ch_newline = '0;
    ch_data    = '0;
    xfer       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == S_RUN && CH_W'(i) == cur_q) begin
        ch_valid[i]                  = !empty;
        ch_newline[i]                = head_nl;
        ch_data[i*DATA_W +: DATA_W]  = head_dat;
        xfer                         = !empty && bus.ch_ready[i];
      end
    end
  end

  // Fixed priority: the descending scan leaves the lowest pending lane selected.
  always_comb begin
    ack    = '0;
    ld     = 1'b0;
    sel    = '0;
    ld_sum = '0;
    if (state_q != S_IDLE && (!sum_valid_q || bus.sum_rd)) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (bus.ch_sum_valid[i]) begin
          ack    = '0;
          ack[i] = 1'b1;
          ld     = 1'b1;
          sel    = CH_W'(i);
          ld_sum = bus.ch_sum[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = xfer ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push && !xfer)      count_d = count_q + 1'b1;
    else if (xfer && !push) count_d = count_q - 1'b1;

    state_d       = state_q;
    cur_d         = cur_q;
    line_cnt_d    = line_cnt_q;
    sum_cnt_d     = sum_cnt_q;
    finalsum_d    = finalsum_q;
    finalsum_ch_d = finalsum_ch_q;
    sum_valid_d   = sum_valid_q;
    cready_d      = 1'b0;

    if (ld) begin
      finalsum_d    = ld_sum;
      finalsum_ch_d = sel;
      sum_valid_d   = 1'b1;
      if (sum_cnt_q != LPF_C) sum_cnt_d = sum_cnt_q + 1'b1;
    end else if (bus.sum_rd) begin
      sum_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cur_d      = '0;
        line_cnt_d = '0;
        sum_cnt_d  = '0;
        if (bus.cStart) state_d = S_RUN;
      end
      S_RUN: begin
        if (xfer && head_nl) begin
          line_cnt_d = line_cnt_q + 1'b1;
          cur_d      = (cur_q == CUR_MAX_C) ? '0 : cur_q + 1'b1;
          if (line_cnt_q == LAST_LINE_C) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sum_cnt_d == LPF_C) state_d = S_DONE;
      end
      S_DONE: begin
        cready_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem_q[wptr_q] <= {bus.newline, bus.dataInput};
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      state_q       <= S_IDLE;
      cur_q         <= '0;
      line_cnt_q    <= '0;
      sum_cnt_q     <= '0;
      finalsum_q    <= '0;
      finalsum_ch_q <= '0;
      sum_valid_q   <= 1'b0;
      cready_q      <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      cur_q         <= cur_d;
      line_cnt_q    <= line_cnt_d;
      sum_cnt_q     <= sum_cnt_d;
      finalsum_q    <= finalsum_d;
      finalsum_ch_q <= finalsum_ch_d;
      sum_valid_q   <= sum_valid_d;
      cready_q      <= cready_d;
    end
  end

`ifdef CONV_HUB_OVF_EN
  logic       ovf_q, ovf_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    ovf_d      = ovf_q | (bus.wr & full);
    drop_cnt_d = drop_cnt_q;
    if (bus.wr && full && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.FULL        = full;
  assign bus.EMPTY       = empty;
  assign bus.cReady      = cready_q;
  assign bus.ch_data     = ch_data;
  assign bus.ch_newline  = ch_newline;
  assign bus.ch_valid    = ch_valid;
  assign bus.ch_sum_ack  = ack;
  assign bus.finalsum    = finalsum_q;
  assign bus.finalsum_ch = finalsum_ch_q;
  assign bus.sum_valid   = sum_valid_q;
endmodule

// File: tb/tb_conv_accel_hub.sv
// Scoreboard bench for conv_accel_hub: dispatched words and collected sums are matched against
// expectation queues filled as stimulus is driven.
module tb_conv_accel_hub;
  localparam int DW = 16, DEPTH = 16, NCH = 2, LPF = 4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_WAIT = 2'd2;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  conv_accel_hub_if #(.DATA_W(DW), .NUM_CH(NCH)) bus ();

  conv_accel_hub #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH), .LINES_PER_FRAME(LPF)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  int cready_cnt = 0, cready_cyc = -10, last_load_cyc = 0;
  logic [17:0] xfer_q [$];   // {lane, newline, data}
  logic [16:0] sum_q  [$];   // {lane, sum}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin : mon
    logic [17:0] e;
    logic [16:0] s;
    if (Rst) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_valid[i] && bus.ch_ready[i]) begin
          if (xfer_q.size() == 0) chk("xfer_unexpected", 1, 0);
          else begin
            e = xfer_q.pop_front();
            chk("xfer_lane", i, 32'(e[17]));
            chk("xfer_data", 32'(bus.ch_data[i*DW +: DW]), 32'(e[15:0]));
            chk("xfer_nl", 32'(bus.ch_newline[i]), 32'(e[16]));
          end
        end
      end
      if (bus.sum_valid && bus.sum_rd) begin
        if (sum_q.size() == 0) chk("sum_unexpected", 1, 0);
        else begin
          s = sum_q.pop_front();
          chk("sum_val", 32'(bus.finalsum), 32'(s[15:0]));
          chk("sum_ch", 32'(bus.finalsum_ch), 32'(s[16]));
        end
        last_load_cyc = cyc;
      end
      if (bus.cReady) begin
        cready_cnt++;
        cready_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    xfer_q.delete();
    sum_q.delete();
  endtask

  task automatic write_word(input logic [15:0] d, input logic nl, input logic lane, input logic keep);
    bus.dataInput = d;
    bus.newline   = nl;
    bus.wr        = 1'b1;
    if (keep) xfer_q.push_back({lane, nl, d});
    tick();
    bus.wr      = 1'b0;
    bus.newline = 1'b0;
  endtask

  task automatic write_frame(input int wpl, input int base);
    for (int l = 0; l < LPF; l++)
      for (int w = 0; w < wpl; w++)
        write_word(16'(base + l*16 + w), (w == wpl-1), 1'(l % NCH), 1'b1);
  endtask

  task automatic start_frame();
    cready_cnt   = 0;
    bus.cStart   = 1'b1;
    tick();
    bus.cStart   = 1'b0;
  endtask

  task automatic drain(input logic rnd);
    int t = 0;
    while (dut.state_q != ST_WAIT && t < 400) begin
      bus.ch_ready = rnd ? 2'($urandom_range(0, 3)) : 2'b11;
      tick();
      t++;
    end
    bus.ch_ready = 2'b00;
    chk("reach_wait", 32'(dut.state_q), 32'(ST_WAIT));
    chk("words_left_at_wait", xfer_q.size(), 0);
  endtask

  task automatic return_sum(input int lane, input logic [15:0] val);
    logic got = 1'b0;
    bus.ch_sum[lane*DW +: DW] = val;
    bus.ch_sum_valid[lane]    = 1'b1;
    sum_q.push_back({1'(lane), val});
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge Clk);
      got = bus.ch_sum_ack[lane];
    end
    chk("sum_ack_seen", 32'(got), 1);
    @(posedge Clk);
    #1;
    bus.ch_sum_valid[lane] = 1'b0;
  endtask

  task automatic finish_frame(input logic [15:0] v0, v1, v2, v3, input int first);
    logic [15:0] v [4];
    v = '{v0, v1, v2, v3};
    bus.sum_rd = 1'b1;
    for (int k = first; k < 4; k++) return_sum(k % NCH, v[k]);
    repeat (3) tick();
    chk("cready_once", cready_cnt, 1);
    chk("cready_latency", cready_cyc, last_load_cyc + 1);
    chk("idle_after_frame", 32'(dut.state_q), 32'(ST_IDLE));
    bus.sum_rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_ovf;
`ifdef CONV_HUB_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    bus.dataInput = '0; bus.wr = 1'b0; bus.newline = 1'b0; bus.cStart = 1'b0;
    bus.ch_ready = '0; bus.ch_sum = '0; bus.ch_sum_valid = '0; bus.sum_rd = 1'b0;

    do_reset();
    chk("rst_empty", 32'(bus.EMPTY), 1);
    chk("rst_full", 32'(bus.FULL), 0);
    chk("rst_cready", 32'(bus.cReady), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    chk("rst_ch_valid", 32'(bus.ch_valid), 0);
    chk("rst_sum_valid", 32'(bus.sum_valid), 0);
    chk("rst_finalsum", 32'(bus.finalsum), 0);
    chk("rst_finalsum_ch", 32'(bus.finalsum_ch), 0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Fill the FIFO while idle, then overrun it by one word.
    for (int i = 0; i < DEPTH; i++)
      write_word(16'(16'h0100 + i), (i % 4) == 3, 1'((i / 4) % NCH), 1'b1);
    chk("fill_full", 32'(bus.FULL), 1);
    chk("fill_not_empty", 32'(bus.EMPTY), 0);
    write_word(16'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("drop_still_full", 32'(bus.FULL), 1);
    chk("drop_ovf", 32'(bus.ovf), 32'(exp_ovf));
    start_frame();
    chk("start_state_run", 32'(dut.state_q), 32'(ST_RUN));
    chk("start_valid_lane0", 32'(bus.ch_valid), 32'h1);
    chk("start_head_word", 32'(bus.ch_data[DW-1:0]), 32'h0100);
    drain(1'b0);
    finish_frame(16'h0101, 16'h0202, 16'h0303, 16'h0404, 0);

    // Four 3-word lines, all lanes ready.
    write_frame(3, 16'h0200);
    start_frame();
    drain(1'b0);
    finish_frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, 0);

    // Both lanes pending together with the result slot occupied.
    write_frame(2, 16'h0300);
    start_frame();
    drain(1'b0);
    bus.ch_sum = {16'h00B0, 16'h00A0};
    bus.ch_sum_valid = 2'b11;
    sum_q.push_back({1'b0, 16'h00A0});
    sum_q.push_back({1'b1, 16'h00B0});
    @(negedge Clk);
    chk("prio_ack_first", 32'(bus.ch_sum_ack), 32'h1);
    @(posedge Clk); #1;
    bus.ch_sum_valid[0] = 1'b0;
    @(negedge Clk);
    chk("prio_hold_ack", 32'(bus.ch_sum_ack), 32'h0);
    chk("prio_hold_ch", 32'(bus.finalsum_ch), 0);
    @(posedge Clk); #1;
    bus.sum_rd = 1'b1;
    @(negedge Clk);
    chk("prio_ack_second", 32'(bus.ch_sum_ack), 32'h2);
    @(posedge Clk); #1;
    bus.ch_sum_valid[1] = 1'b0;
    finish_frame(16'h0000, 16'h0000, 16'h00C0, 16'h00D0, 2);

    // Lane readiness toggled at random.
    write_frame(3, 16'h0400);
    start_frame();
    drain(1'b1);
    finish_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0);

    // Reset in the middle of a frame with buffered words and a held result.
    for (int i = 0; i < 5; i++) write_word(16'(16'h0500 + i), 1'b0, 1'b0, 1'b1);
    start_frame();
    bus.ch_sum[DW +: DW] = 16'h0BAD;
    bus.ch_sum_valid[1]  = 1'b1;
    tick();
    bus.ch_sum_valid[1]  = 1'b0;
    chk("pre_rst_sum_valid", 32'(bus.sum_valid), 1);
    do_reset();
    chk("mid_rst_empty", 32'(bus.EMPTY), 1);
    chk("mid_rst_ch_valid", 32'(bus.ch_valid), 0);
    chk("mid_rst_sum_valid", 32'(bus.sum_valid), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    write_frame(3, 16'h0600);
    start_frame();
    drain(1'b0);
    finish_frame(16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04, 0);

    chk("sums_all_consumed", sum_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_accel_hub.md
Name: conv_accel_hub

Overview:
Parametrised successor to the single-channel processor-to-accelerator link. It sits between the Zynq processor block design and NUM_CH convolution accelerator lanes. Host writes are buffered in an input FIFO. Each written word carries an end-of-line tag, and whole image lines are dispatched round-robin to the lanes. Per-line sums returned by the lanes are collected into one tagged result register, and a frame-complete cReady pulse is raised when all sums are back.

Parameters:
DATA_W, 16, data and sum width in bits
FIFO_DEPTH, 16, input FIFO entries; must be a power of 2, minimum 2
NUM_CH, 2, number of accelerator lanes, 1..8
LINES_PER_FRAME, 8, lines per frame; each line yields exactly one sum
CH_W, max(1,$clog2(NUM_CH)), lane index width (derived)

Ports:
Clk  in  1  single system clock, all logic on rising edge
Rst  in  1  synchronous, active-low reset
dataInput  in  DATA_W  host write data
wr  in  1  host write strobe, one word per cycle
newline  in  1  tag sampled with wr; marks the last word of a line
cStart  in  1  frame start, level-sampled
FULL  out  1  input FIFO full
EMPTY  out  1  input FIFO empty
cReady  out  1  one-cycle frame-complete pulse
ovf  out  1  sticky overflow flag (optional feature; otherwise tied 0)
ch_data  out  NUM_CH*DATA_W  lane data; lane i occupies bits [i*DATA_W +: DATA_W]
ch_newline  out  NUM_CH  end-of-line tag per lane
ch_valid  out  NUM_CH  lane data valid
ch_ready  in  NUM_CH  lane accepts data
ch_sum  in  NUM_CH*DATA_W  per-lane line sum
ch_sum_valid  in  NUM_CH  lane sum pending
ch_sum_ack  out  NUM_CH  sum consumed (combinational)
finalsum  out  DATA_W  collected sum
finalsum_ch  out  CH_W  lane that produced finalsum
sum_valid  out  1  finalsum holds unread data
sum_rd  in  1  host consumes finalsum

Behaviour:
- Reset (Rst=0 at a rising edge) clears the FIFO pointers, the count, all counters and the FSM.
  - Resulting outputs: EMPTY=1, FULL=0, cReady=0, ovf=0, ch_valid=0, sum_valid=0, finalsum=0, finalsum_ch=0, state IDLE.
  - A reset mid-frame discards buffered data and any held result; ch_valid is low the cycle after reset.
- Input FIFO: entry = {newline, dataInput}, show-ahead head.
  - FULL = (count==FIFO_DEPTH); EMPTY = (count==0).
  - wr while FULL drops the word, even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Writes are accepted in every state, so data written in IDLE is buffered.
- FSM states:
  - IDLE: cStart=1 → RUN. Clears the lane pointer cur, line_cnt and sum_cnt.
  - RUN: ch_valid[cur] = !EMPTY; all other ch_valid bits are 0. ch_data lane cur and ch_newline[cur] come from the FIFO head.
    - A transfer is ch_valid[cur] & ch_ready[cur]; the FIFO pops on transfer.
    - A transfer with the newline tag set increments line_cnt and advances cur to (cur+1) mod NUM_CH.
    - A newline transfer when line_cnt==LINES_PER_FRAME-1 → WAIT.
  - WAIT: no dispatch. When sum_cnt reaches LINES_PER_FRAME (counting an ack in the same cycle) → DONE.
  - DONE: cReady=1 for exactly one cycle → IDLE.
- cStart outside IDLE is ignored.
- Sums are collected in every non-IDLE state; sums arriving during RUN count toward the frame.
- Collection:
  - Load slot is free when !sum_valid || sum_rd.
  - If free, ch_sum_ack is asserted combinationally for the lowest-index lane with ch_sum_valid set (fixed priority).
  - Next edge: finalsum = that lane's sum, finalsum_ch = its index, sum_valid=1, sum_cnt increments.
  - Latency ch_sum_valid→sum_valid is 1 cycle.
  - sum_rd with no new load clears sum_valid; sum_rd with a load back-to-back keeps sum_valid=1.
- Line length is not counted; the newline tag alone delimits lines.
- Sums beyond LINES_PER_FRAME are still acked but do not re-trigger cReady.

Optional Feature:
CONV_HUB_OVF_EN.
- Defined: ovf is set on any wr while FULL and stays 1 until reset. Write-while-full is additionally counted in an 8-bit saturating drop counter, readable only in simulation via hierarchy.
- Undefined: ovf is tied 0, no counter is built, and dropped writes are silent.
- The ovf port exists in both builds.

Test Plan:
- Reset then write 16 words with FIFO_DEPTH=16 and cStart=0 → FULL=1, EMPTY=0; a 17th write is dropped (ovf=1 when the feature is enabled); after frame start, the head word equals the first written value.
- NUM_CH=2, LINES_PER_FRAME=4, four lines of 3 words each (newline on every 3rd word), cStart pulse, all ch_ready=1 → lines go to lanes 0,1,0,1 in order; state WAIT after the 12th transfer.
- Same frame, lanes return sums 0x0011, 0x0022, 0x0033, 0x0044 with sum_rd held high → finalsum sequence matches with finalsum_ch 0,1,0,1; cReady pulses once, 1 cycle after the 4th load.
- Both lanes assert ch_sum_valid in the same cycle with sum_rd=0 → lane 0 acked first; lane 1 is acked only in the cycle sum_rd=1.
- Toggle ch_ready[cur] randomly during RUN → no word is lost or duplicated, and data on each lane is in write order.
- Rst=0 for one cycle mid-RUN with 5 words buffered → next cycle EMPTY=1, ch_valid=0, sum_valid=0, state IDLE; a following cStart runs a clean frame.
